// File: rtl/jpeg_stream_pkg.sv
// ------------------------------------------------------------------
// jpeg_stream_pkg : shared register map, bus constants and FSM states
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package jpeg_stream_pkg;

  localparam logic [1:0] REG_DATA  = 2'b00;
  localparam logic [1:0] REG_DEPTH = 2'b10;
  localparam logic [1:0] REG_END   = 2'b11;

  localparam logic BUS_WRITE = 1'b0;
  localparam logic BUS_READ  = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    POLL  = 3'd2,
    DRAIN = 3'd3,
    EOFRD = 3'd4,
    FLUSH = 3'd5
  } state_e;

  // Register select lives in address bits [9:8]; the rest comes from the base.
  function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [1:0] off);
    reg_addr = (base & ~32'h0000_0300) | {22'd0, off, 8'd0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/jpeg_out_hold.sv
// ------------------------------------------------------------------
// jpeg_out_hold : one presented word plus one held-back word, so the
// final word can still receive its last/eof tag. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module jpeg_out_hold (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [31:0] load_data_i,
  input  logic        tag_i,
  input  logic [4:0]  tag_bits_i,
  output logic        space_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic        out_last_o,
  output logic [4:0]  out_eof_bits_o
);

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q,  out_data_d;
  logic        out_last_q,  out_last_d;
  logic [4:0]  out_bits_q,  out_bits_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_data_q,  hold_data_d;
  logic        w_fire;

  assign w_fire  = out_valid_q & out_ready_i;
  assign space_o = ~out_valid_q | w_fire;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_bits_q   <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_bits_q   <= out_bits_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_bits_d   = out_bits_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (w_fire) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_bits_d  = '0;
    end
    // A new word releases the previously held one onto the stream.
    if (load_i) begin
      if (hold_valid_q) begin
        out_valid_d = 1'b1;
        out_data_d  = hold_data_q;
        out_last_d  = 1'b0;
        out_bits_d  = '0;
      end
      hold_valid_d = 1'b1;
      hold_data_d  = load_data_i;
    end
    if (tag_i) begin
      out_valid_d  = 1'b1;
      out_data_d   = hold_valid_q ? hold_data_q : 32'd0;
      out_last_d   = 1'b1;
      out_bits_d   = tag_bits_i;
      hold_valid_d = 1'b0;
    end
  end

  assign out_valid_o    = out_valid_q;
  assign out_data_o     = out_data_q;
  assign out_last_o     = out_last_q;
  assign out_eof_bits_o = out_bits_q;

endmodule

`default_nettype wire

// File: rtl/jpeg_stream_master.sv
// ------------------------------------------------------------------
// jpeg_stream_master : writes 8x8 pixel blocks to the JPEG encoder and
// drains the compressed FIFO into a valid/ready stream. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module jpeg_stream_master
  import jpeg_stream_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          BLOCK_WORDS = 64,
  parameter int          DEPTH_W     = 6
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pix_valid_i,
  output logic        pix_ready_o,
  input  logic [31:0] pix_data_i,
  input  logic        pix_last_blk_i,
  output logic        bus_req_o,
  output logic [31:0] bus_add_o,
  output logic        bus_wen_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_r_valid_i,
  input  logic [31:0] bus_r_rdata_i,
  input  logic        end_irq_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic        out_last_o,
  output logic [4:0]  out_eof_bits_o,
  output logic        busy_o
);

  localparam int CNT_W = $clog2(BLOCK_WORDS + 1);

  state_e             state_q,    state_d;
  logic [CNT_W-1:0]   wcnt_q,     wcnt_d;
  logic [DEPTH_W-1:0] dcnt_q,     dcnt_d;
  logic               last_blk_q, last_blk_d;
  logic               rd_pend_q,  rd_pend_d;
  logic               end_seen_q, end_seen_d;

  logic               w_rd_done;
  logic               w_space;
  logic               w_hold_load;
  logic               w_hold_tag;
  logic [DEPTH_W-1:0] w_rd_depth;

  assign w_rd_done   = rd_pend_q & bus_r_valid_i;
  assign w_rd_depth  = bus_r_rdata_i[DEPTH_W-1:0];
  assign w_hold_load = w_rd_done & (state_q == DRAIN);
  assign w_hold_tag  = w_rd_done & (state_q == EOFRD);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      dcnt_q     <= '0;
      last_blk_q <= 1'b0;
      rd_pend_q  <= 1'b0;
      end_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      dcnt_q     <= dcnt_d;
      last_blk_q <= last_blk_d;
      rd_pend_q  <= rd_pend_d;
      end_seen_q <= end_seen_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    dcnt_d     = dcnt_q;
    last_blk_d = last_blk_q;
    end_seen_d = end_seen_q;
    rd_pend_d  = rd_pend_q;
    if (bus_req_o && bus_gnt_i && (bus_wen_o == BUS_READ)) rd_pend_d = 1'b1;
    if (w_rd_done) rd_pend_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pix_valid_i) begin
          last_blk_d = pix_last_blk_i;
          wcnt_d     = CNT_W'(BLOCK_WORDS);
          state_d    = WR;
        end
      end
      WR: begin
        if (pix_ready_o) begin
          wcnt_d = wcnt_q - CNT_W'(1);
          if (wcnt_q == CNT_W'(1)) state_d = POLL;
        end
      end
      POLL: begin
        if (w_rd_done) begin
          if (w_rd_depth != '0) begin
            dcnt_d  = w_rd_depth;
            state_d = DRAIN;
          end else if (!last_blk_q) begin
            state_d = IDLE;
          end else if (end_seen_q) begin
            state_d = EOFRD;
          end
        end
      end
      DRAIN: begin
        if (w_rd_done) begin
          dcnt_d = dcnt_q - DEPTH_W'(1);
          if (dcnt_q == DEPTH_W'(1)) state_d = POLL;
        end
      end
      EOFRD: begin
        if (w_rd_done) state_d = FLUSH;
      end
      FLUSH: begin
        if (out_valid_o && out_ready_i) begin
          state_d    = IDLE;
          end_seen_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // A pulse coinciding with the FLUSH clear must not be lost.
    if (end_irq_i) end_seen_d = 1'b1;
  end

  always_comb begin
    bus_req_o   = 1'b0;
    bus_add_o   = '0;
    bus_wen_o   = BUS_WRITE;
    bus_wdata_o = '0;
    case (state_q)
      WR: begin
        bus_req_o = pix_valid_i;
        if (pix_valid_i) begin
          bus_add_o   = reg_addr(BASE_ADDR, {1'b0, last_blk_q});
          bus_wdata_o = pix_data_i;
        end
      end
      POLL: begin
        if (!rd_pend_q) begin
          bus_req_o = 1'b1;
          bus_add_o = reg_addr(BASE_ADDR, REG_DEPTH);
          bus_wen_o = BUS_READ;
        end
      end
      DRAIN: begin
        if (!rd_pend_q && w_space) begin
          bus_req_o = 1'b1;
          bus_add_o = reg_addr(BASE_ADDR, REG_DATA);
          bus_wen_o = BUS_READ;
        end
      end
      EOFRD: begin
        if (!rd_pend_q && w_space) begin
          bus_req_o = 1'b1;
          bus_add_o = reg_addr(BASE_ADDR, REG_END);
          bus_wen_o = BUS_READ;
        end
      end
      default: ;
    endcase
    pix_ready_o = (state_q == WR) & bus_req_o & bus_gnt_i;
    busy_o      = (state_q != IDLE);
  end

  jpeg_out_hold u_hold (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .load_i         (w_hold_load),
    .load_data_i    (bus_r_rdata_i),
    .tag_i          (w_hold_tag),
    .tag_bits_i     (bus_r_rdata_i[4:0]),
    .space_o        (w_space),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_data_o     (out_data_o),
    .out_last_o     (out_last_o),
    .out_eof_bits_o (out_eof_bits_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_jpeg_stream_master.sv
// ------------------------------------------------------------------
// tb_jpeg_stream_master : encoder responder model plus stream scoreboard
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_jpeg_stream_master;
  import jpeg_stream_pkg::*;

  localparam logic [31:0] BASE = 32'hA000_0400;

  typedef struct packed {logic last; logic [31:0] data;} pix_t;
  typedef struct {bit last; int nwords; int irq_after;} blk_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_valid = 1'b0, pix_last_blk = 1'b0;
  logic [31:0] pix_data = '0;
  logic        pix_ready;
  logic        bus_req, bus_wen;
  logic [31:0] bus_add, bus_wdata;
  logic        gnt = 1'b0, r_valid = 1'b0, end_irq = 1'b0, out_ready = 1'b0;
  logic [31:0] r_rdata = '0;
  logic        out_valid, out_last, busy;
  logic [31:0] out_data;
  logic [4:0]  out_eof;

  jpeg_stream_master #(.BASE_ADDR(BASE), .BLOCK_WORDS(64), .DEPTH_W(6)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .pix_valid_i(pix_valid), .pix_ready_o(pix_ready), .pix_data_i(pix_data),
    .pix_last_blk_i(pix_last_blk),
    .bus_req_o(bus_req), .bus_add_o(bus_add), .bus_wen_o(bus_wen), .bus_wdata_o(bus_wdata),
    .bus_gnt_i(gnt), .bus_r_valid_i(r_valid), .bus_r_rdata_i(r_rdata),
    .end_irq_i(end_irq),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_last_o(out_last), .out_eof_bits_o(out_eof), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;

  // Encoder/bus responder and stream reference state
  pix_t        pix_q[$];
  blk_t        blk_q[$];
  logic [31:0] exp_q[$];
  int  gnt_pct = 100, rdy_pct = 100;
  bit  partial = 0;
  int  avail = 0, wr_in_blk = 0, zero_polls = 0, enc_irq_after = 0, stream_words = 0;
  bit  enc_last = 0, irq_now = 0, irq_fired = 0, end_done = 0;
  bit  rd_busy = 0;
  int  rd_lat = 0;
  logic [31:0] rd_data = '0;
  logic [4:0]  eof_bits = '0;
  bit  prev_hold = 0;
  logic [31:0] prev_add = '0, prev_wdata = '0;
  logic        prev_wen = 1'b0;
  int  ready_low = 0;
  bit  stall_arm = 0;
  int  n_wr = 0, n_data_rd = 0, n_emit = 0, n_last = 0, n_full_rd = 0;

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    logic        exp_last;
    logic [31:0] rd;
    int          d;
    @(negedge clk);
    if (rd_busy && rd_lat == 0) begin
      r_valid = 1'b1; r_rdata = rd_data; rd_busy = 0;
    end else begin
      if (rd_busy) rd_lat--;
      r_valid = 1'b0; r_rdata = $urandom;
    end
    end_irq = irq_now;
    if (irq_now) irq_fired = 1;
    irq_now = 0;
    gnt = ($urandom_range(99) < gnt_pct);
    if (pix_q.size() != 0) begin
      pix_valid = 1'b1; pix_data = pix_q[0].data; pix_last_blk = pix_q[0].last;
    end else begin
      pix_valid = 1'b0; pix_data = $urandom; pix_last_blk = 1'b0;
    end
    out_ready = (ready_low > 0) ? 1'b0 : ($urandom_range(99) < rdy_pct);
    if (ready_low > 0) ready_low--;
    #1;
    // Bus protocol: stable request until granted, single outstanding read
    if (prev_hold) begin
      check_eq("req_hold", bus_req, 1'b1);
      check_eq("req_stable", {bus_add, bus_wdata, 7'd0, bus_wen}, {prev_add, prev_wdata, 7'd0, prev_wen});
    end
    if (rd_busy || r_valid) check_eq("one_outstanding", bus_req, 1'b0);
    // Output stream against reference order
    if (out_valid && out_ready) begin
      check_eq("out_nonempty", 72'(exp_q.size() != 0), 72'd1);
      if (exp_q.size() != 0) begin
        exp_last = end_done && (exp_q.size() == 1);
        check_eq("out_data", out_data, exp_q[0]);
        check_eq("out_tag", {out_last, out_eof}, {exp_last, exp_last ? eof_bits : 5'd0});
        void'(exp_q.pop_front());
        n_emit++;
        if (exp_last) begin end_done = 0; n_last++; end
      end
    end
    // Pixel writes
    if (bus_req && gnt && bus_wen == BUS_WRITE) begin
      check_eq("pix_ready", pix_ready, 1'b1);
      if (pix_q.size() != 0) begin
        check_eq("wr_data", bus_wdata, pix_q[0].data);
        check_eq("wr_addr", bus_add, {BASE[31:10], 1'b0, pix_q[0].last, BASE[7:0]});
        void'(pix_q.pop_front());
      end
      n_wr++; wr_in_blk++;
      if (blk_q.size() != 0) begin
        if (wr_in_blk == 10 && blk_q[0].last && blk_q[0].irq_after < 0) irq_now = 1;
        if (wr_in_blk == 64) begin
          avail += blk_q[0].nwords;
          enc_last = blk_q[0].last;
          enc_irq_after = blk_q[0].irq_after;
          zero_polls = 0;
          if (enc_last && enc_irq_after == 0) irq_now = 1;
          void'(blk_q.pop_front());
          wr_in_blk = 0;
        end
      end
    end else if (pix_ready) begin
      check_eq("pix_ready_spurious", pix_ready, 1'b0);
    end
    // Register reads
    if (bus_req && gnt && bus_wen == BUS_READ) begin
      check_eq("rd_addr_base", {bus_add[31:10], bus_add[7:0]}, {BASE[31:10], BASE[7:0]});
      rd = $urandom;
      case (bus_add[9:8])
        REG_DEPTH: begin
          d = (avail == 0) ? 0 : (partial ? int'($urandom_range(1, avail)) : avail);
          rd = (rd & ~32'h3F) | 32'(d);
          if (d == 0 && enc_last) begin
            zero_polls++;
            if (zero_polls == enc_irq_after) irq_now = 1;
          end
        end
        REG_DATA: begin
          check_eq("data_rd_avail", 72'(avail > 0), 72'd1);
          if (avail > 0) avail--;
          exp_q.push_back(rd);
          stream_words++; n_data_rd++;
          if (out_valid && !out_ready) n_full_rd++;
          if (stall_arm) begin ready_low = 20; stall_arm = 0; end
        end
        REG_END: begin
          check_eq("end_after_irq", {irq_fired, enc_last}, 2'b11);
          rd = (rd & ~32'h1F) | 32'(eof_bits);
          if (stream_words == 0) exp_q.push_back(32'd0);
          end_done = 1; stream_words = 0; irq_fired = 0; enc_last = 0;
        end
        default: check_eq("rd_offset", bus_add[9:8], REG_DEPTH);
      endcase
      rd_busy = 1; rd_lat = $urandom_range(2); rd_data = rd;
    end
    prev_hold = bus_req && !gnt;
    prev_add = bus_add; prev_wdata = bus_wdata; prev_wen = bus_wen;
  endtask

  task automatic run_block(input bit last, input int nwords, input int irq_after);
    blk_t b;
    int   n, wr0;
    b.last = last; b.nwords = nwords; b.irq_after = irq_after;
    blk_q.push_back(b);
    for (int i = 0; i < 64; i++) pix_q.push_back(pix_t'({last, $urandom}));
    wr0 = n_wr; n = 0;
    do begin cycle(); n++; end while ((pix_q.size() != 0 || busy) && n < 4000);
    check_eq("blk_timeout", 72'(n < 4000), 72'd1);
    check_eq("blk_writes", 72'(n_wr - wr0), 72'd64);
  endtask

  initial begin
    int e0, d0, l0, f0, nb, n;
    repeat (3) @(negedge clk);
    check_eq("rst_bus", {bus_req, bus_wen, bus_add, bus_wdata}, 72'd0);
    check_eq("rst_out", {out_valid, out_last, out_eof, out_data}, 72'd0);
    check_eq("rst_misc", {pix_ready, busy}, 2'b00);
    rst_n = 1'b1;

    // Non-last block, three compressed words
    e0 = n_emit; d0 = n_data_rd;
    run_block(0, 3, 0);
    check_eq("t1_data_reads", 72'(n_data_rd - d0), 72'd3);
    check_eq("t1_emitted", 72'(n_emit - e0), 72'd2);
    check_eq("t1_held", 72'(exp_q.size()), 72'd1);
    check_eq("t1_busy", busy, 1'b0);

    // Last block: two empty polls, then the end pulse, eof = 17
    eof_bits = 5'd17; e0 = n_emit; l0 = n_last;
    run_block(1, 0, 2);
    check_eq("t2_emitted", 72'(n_emit - e0), 72'd1);
    check_eq("t2_last", 72'(n_last - l0), 72'd1);
    check_eq("t2_zero_polls", 72'(zero_polls >= 2), 72'd1);
    check_eq("t2_drained", 72'(exp_q.size()), 72'd0);

    // Empty stream, end pulse during writes: a lone zero word
    eof_bits = 5'($urandom); e0 = n_emit; l0 = n_last;
    run_block(1, 0, -1);
    check_eq("t5_emitted", 72'(n_emit - e0), 72'd1);
    check_eq("t5_last", 72'(n_last - l0), 72'd1);

    // Randomized streams with grant/ready stalls and partial depths
    gnt_pct = 50; rdy_pct = 70; partial = 1;
    for (int s = 0; s < 3; s++) begin
      nb = $urandom_range(1, 3); l0 = n_last;
      eof_bits = 5'($urandom);
      for (int b = 0; b < nb; b++)
        run_block(b == nb - 1, $urandom_range(0, 6), int'($urandom_range(0, 3)) - 1);
      check_eq("rnd_last", 72'(n_last - l0), 72'd1);
      check_eq("rnd_drained", 72'(exp_q.size()), 72'd0);
    end

    // Downstream stall of 20 cycles while draining five words
    gnt_pct = 100; rdy_pct = 100; partial = 0; stall_arm = 1;
    f0 = n_full_rd; e0 = n_emit; eof_bits = 5'd3;
    run_block(0, 5, 0);
    run_block(1, 0, 0);
    check_eq("t4_full_reads", 72'(n_full_rd - f0 <= 1), 72'd1);
    check_eq("t4_emitted", 72'(n_emit - e0), 72'd5);
    check_eq("t4_drained", 72'(exp_q.size()), 72'd0);

    // Asynchronous reset in the middle of a block
    blk_q.push_back('{0, 4, 0});
    for (int i = 0; i < 64; i++) pix_q.push_back(pix_t'({1'b0, $urandom}));
    n = 0;
    do begin cycle(); n++; end while (wr_in_blk < 30 && n < 400);
    check_eq("t6_reached", 72'(wr_in_blk >= 30), 72'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_req_async", bus_req, 1'b0);
    check_eq("t6_busy_async", {busy, out_valid}, 2'b00);
    pix_q.delete(); blk_q.delete(); exp_q.delete();
    avail = 0; wr_in_blk = 0; zero_polls = 0; stream_words = 0;
    enc_last = 0; irq_now = 0; irq_fired = 0; end_done = 0;
    rd_busy = 0; r_valid = 1'b0; prev_hold = 0; ready_low = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_block(0, 0, 0);
    check_eq("t6_busy_end", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
